pll_reset_sequencer: RTL and testbench

Generates the design-wide synchronous reset from the ECP5 PLL `locked` output and supervises lock for the life of the design. It runs in the PLL output clock domain (142.857 MHz SOBEL clock) and synchronises the asynchronous `locked` pin. Reset is released only after lock has been stable for a programmable hold-off. A filtered loss of lock re-asserts reset and is recorded in sticky status for the host/debug path.

---
 rtl/pll_reset_sequencer.sv | 117 +++++++++++
 tb/tb_pll_reset_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// Turns the asynchronous PLL lock into the design-wide synchronous reset, with a stability hold-off and filtered loss detection.
// Outputs are registered from next-state: reset releases 3+STABLE_CYCLES edges after lock and re-asserts 2+LOSS_FILTER edges after loss.
module pll_reset_sequencer #(
   parameter int STABLE_CYCLES = 1024,
   parameter int LOSS_FILTER   = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             locked,
   input  logic             clear,
   output logic             rst_out,
   output logic             ready,
   output logic             lock_lost,
   output logic [CNT_W-1:0] loss_count
);

   localparam int SCNT_W = $clog2(STABLE_CYCLES);
   localparam int FCNT_W = $clog2(LOSS_FILTER) + 1;
   localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STABLE_CYCLES - 1);
   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(LOSS_FILTER - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABILIZE = 2'd1,
      RUN       = 2'd2,
      LOST      = 2'd3
   } state_t;

   logic              r_s1;
   logic              r_ls;
   state_t            r_state;
   logic [SCNT_W-1:0] r_scnt;
   logic [FCNT_W-1:0] r_fcnt;

   state_t            w_state_nxt;
   logic [SCNT_W-1:0] w_scnt_nxt;
   logic [FCNT_W-1:0] w_fcnt_nxt;
   logic              w_loss;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1       <= 1'b0;
         r_ls       <= 1'b0;
         r_state    <= WAIT_LOCK;
         r_scnt     <= '0;
         r_fcnt     <= '0;
         rst_out    <= 1'b1;
         ready      <= 1'b0;
         lock_lost  <= 1'b0;
         loss_count <= '0;
      end else begin
         r_s1    <= locked;
         r_ls    <= r_s1;
         r_state <= w_state_nxt;
         r_scnt  <= w_scnt_nxt;
         r_fcnt  <= w_fcnt_nxt;
         rst_out <= (w_state_nxt != RUN);
         ready   <= (w_state_nxt == RUN);
         // A loss coinciding with clear restarts the count at one rather than zero.
         if (w_loss) begin
            lock_lost <= 1'b1;
            if (clear)
               loss_count <= CNT_W'(1);
            else if (loss_count != '1)
               loss_count <= loss_count + CNT_W'(1);
         end else if (clear) begin
            lock_lost  <= 1'b0;
            loss_count <= '0;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_scnt_nxt  = r_scnt;
      w_fcnt_nxt  = r_fcnt;
      w_loss      = 1'b0;
      case (r_state)
         WAIT_LOCK: begin
            w_fcnt_nxt = '0;
            if (r_ls) begin
               w_state_nxt = STABILIZE;
               w_scnt_nxt  = '0;
            end
         end
         STABILIZE: begin
            if (!r_ls)
               w_state_nxt = WAIT_LOCK;
            else if (r_scnt == SCNT_LAST)
               w_state_nxt = RUN;
            else
               w_scnt_nxt = r_scnt + SCNT_W'(1);
         end
         RUN: begin
            if (!r_ls) begin
               if (r_fcnt == FCNT_LAST) begin
                  w_state_nxt = LOST;
                  w_fcnt_nxt  = '0;
                  w_loss      = 1'b1;
               end else begin
                  w_fcnt_nxt = r_fcnt + FCNT_W'(1);
               end
            end else begin
               w_fcnt_nxt = '0;
            end
         end
         LOST: begin
            w_state_nxt = WAIT_LOCK;
         end
         default: begin
            w_state_nxt = WAIT_LOCK;
         end
      endcase
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench: a vector table for reset, acquisition, glitch and loss, plus hand sequences for the multi-cycle corner cases.
module tb_pll_reset_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       locked;
   logic       clear;
   logic       rst_out;
   logic       ready;
   logic       lock_lost;
   logic [7:0] loss_count;

   int total = 0;
   int bad   = 0;

   pll_reset_sequencer #(
      .STABLE_CYCLES(16),
      .LOSS_FILTER  (4),
      .CNT_W        (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .locked    (locked),
      .clear     (clear),
      .rst_out   (rst_out),
      .ready     (ready),
      .lock_lost (lock_lost),
      .loss_count(loss_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       locked;
      logic       clear;
      logic       e_rst_out;
      logic       e_ready;
      logic       e_lock_lost;
      logic [7:0] e_count;
      string      tag;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic r, input logic l, input logic c,
                               input logic ero, input logic erd, input logic ell,
                               input logic [7:0] ecnt, input string tag);
      vec_t v;
      v.rst = r; v.locked = l; v.clear = c;
      v.e_rst_out = ero; v.e_ready = erd; v.e_lock_lost = ell; v.e_count = ecnt;
      v.tag = tag;
      vecs.push_back(v);
   endfunction

   // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input logic ero, input logic erd,
                          input logic ell, input logic [7:0] ecnt);
      chk({name, ".rst_out"},    int'(rst_out),    int'(ero));
      chk({name, ".ready"},      int'(ready),      int'(erd));
      chk({name, ".lock_lost"},  int'(lock_lost),  int'(ell));
      chk({name, ".loss_count"}, int'(loss_count), int'(ecnt));
   endtask

   // Loss of 4 locked-low cycles, optional clear on the loss edge (edge 6), re-lock reaching RUN at edge 24.
   task automatic loss_relock(input logic clr);
      for (int e = 1; e <= 24; e++) begin
         locked = (e >= 5);
         clear  = clr && (e == 6);
         tick();
      end
      clear = 1'b0;
   endtask

   initial begin
      rst = 1'b1; locked = 1'b1; clear = 1'b0;

      // Reset held 3 cycles with locked high.
      for (int i = 0; i < 3; i++) add(1, 1, 0, 1, 0, 0, 8'd0, "reset");
      // Acquisition: RUN after edge 19.
      for (int e = 1; e <= 19; e++) add(0, 1, 0, (e < 19), (e >= 19), 0, 8'd0, "acquire");
      for (int e = 1; e <= 3; e++) add(0, 1, 0, 0, 1, 0, 8'd0, "run");
      // Three-cycle glitch is rejected.
      for (int e = 1; e <= 9; e++) add(0, (e > 3), 0, 0, 1, 0, 8'd0, "glitch");
      // Four-cycle loss: LOST after edge 6, back in RUN after edge 24.
      for (int e = 1; e <= 5; e++) add(0, (e >= 5), 0, 0, 1, 0, 8'd0, "loss_pre");
      for (int e = 6; e <= 23; e++) add(0, 1, 0, 1, 0, 1, 8'd1, "loss_relock");
      add(0, 1, 0, 0, 1, 1, 8'd1, "relock_run");

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; locked = vecs[i].locked; clear = vecs[i].clear;
         tick();
         chk_all($sformatf("%s[%0d]", vecs[i].tag, i), vecs[i].e_rst_out,
                 vecs[i].e_ready, vecs[i].e_lock_lost, vecs[i].e_count);
      end

      // Reset for one cycle in RUN clears status; re-release after 19 edges.
      rst = 1'b1; locked = 1'b1;
      tick();
      chk_all("midrun_rst", 1, 0, 0, 8'd0);
      rst = 1'b0;
      for (int e = 1; e <= 19; e++) begin
         tick();
         chk($sformatf("midrun_rel_rst_out[e%0d]", e), int'(rst_out), int'(e < 19));
      end
      chk("midrun_rel_ready", int'(ready), 1);

      // Drop at edge 10 during STABILIZE: hold restarts, RUN after edge 29, no loss recorded.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int e = 1; e <= 29; e++) begin
         locked = (e != 10);
         tick();
         chk($sformatf("stab_drop_rst_out[e%0d]", e), int'(rst_out), int'(e < 29));
         chk($sformatf("stab_drop_cnt[e%0d]", e), int'(loss_count), 0);
      end
      chk("stab_drop_ready", int'(ready), 1);
      chk("stab_drop_lost", int'(lock_lost), 0);

      // 256 losses saturate the counter at 255.
      for (int n = 1; n <= 256; n++) begin
         loss_relock(1'b0);
         chk($sformatf("sat_cnt[%0d]", n), int'(loss_count), (n > 255) ? 255 : n);
      end
      chk("sat_lost", int'(lock_lost), 1);
      chk("sat_ready", int'(ready), 1);

      // Clear coinciding with the 257th loss: loss wins.
      loss_relock(1'b1);
      chk_all("clear_with_loss", 0, 1, 1, 8'd1);

      // Lone clear.
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk_all("lone_clear", 0, 1, 0, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
